// File: rtl/uart_transmit_buffered.sv
// uart_transmit_buffered: 8N1 UART transmitter with a one-byte holding register for gapless back-to-back frames
module uart_transmit_buffered #(
  parameter int CYCLES_PER_BIT = 217,
  parameter int STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_serial_tx,
  output logic       o_tx_active,
  output logic       o_tx_done
);
  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, hold, hold_n;
  logic full, full_n, tx, tx_n, bit_end, frame_end;
  assign bit_end = cnt == LAST;
  assign frame_end = state == STOP && bit_end && idx == STOP_LAST;
  assign o_tx_ready = ~full;
  assign o_serial_tx = tx;
  assign o_tx_active = state != IDLE;
  assign o_tx_done = frame_end;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      hold <= '0;
      full <= 1'b0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      hold <= hold_n;
      full <= full_n;
      tx <= tx_n;
    end
  end
  // idx counts data bits in DATA and stop bits in STOP; it wraps to 0 leaving DATA
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    hold_n = hold;
    full_n = full;
    tx_n = tx;
    if (i_tx_valid && !full) begin
      hold_n = i_tx_byte;
      full_n = 1'b1;
    end
    case (state)
      START: if (bit_end) begin
        state_n = DATA;
        tx_n = shift[0];
      end
      DATA: if (bit_end) begin
        idx_n = idx + 3'd1;
        shift_n = {1'b0, shift[7:1]};
        tx_n = idx == 3'd7 ? 1'b1 : shift[1];
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        idx_n = frame_end ? 3'd0 : idx + 3'd1;
        state_n = frame_end ? IDLE : STOP;
      end
      default: ;
    endcase
    if (full && (state == IDLE || frame_end)) begin
      shift_n = hold;
      full_n = 1'b0;
      state_n = START;
      tx_n = 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_transmit_buffered.sv
// tb_uart_transmit_buffered: table vectors, corner sequences and random traffic against a line-waveform queue model
module tb_uart_transmit_buffered;
  logic clk = 0;
  logic rst = 1;
  logic [7:0] data = 0;
  logic valid = 0;
  int sel = 0;
  logic [2:0] rdy, ser, act, dn;
  int total = 0;
  int passed = 0;
  bit q[$];
  bit m_full = 0;
  logic [7:0] m_byte = 0;
  logic lg[$];
  logic [7:0] rx_b[$];
  int rx_t[$];
  typedef struct {
    int sel;
    logic [7:0] b;
    int len;
    logic [10:0] pat;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_transmit_buffered #(.CYCLES_PER_BIT(4), .STOP_BITS(1)) u0 (
    .i_clk(clk), .i_reset(rst), .i_tx_byte(data), .i_tx_valid(valid && sel == 0),
    .o_tx_ready(rdy[0]), .o_serial_tx(ser[0]), .o_tx_active(act[0]), .o_tx_done(dn[0]));
  uart_transmit_buffered #(.CYCLES_PER_BIT(4), .STOP_BITS(2)) u1 (
    .i_clk(clk), .i_reset(rst), .i_tx_byte(data), .i_tx_valid(valid && sel == 1),
    .o_tx_ready(rdy[1]), .o_serial_tx(ser[1]), .o_tx_active(act[1]), .o_tx_done(dn[1]));
  uart_transmit_buffered #(.CYCLES_PER_BIT(217), .STOP_BITS(1)) u2 (
    .i_clk(clk), .i_reset(rst), .i_tx_byte(data), .i_tx_valid(valid && sel == 2),
    .o_tx_ready(rdy[2]), .o_serial_tx(ser[2]), .o_tx_active(act[2]), .o_tx_done(dn[2]));

  function automatic int cpb_of(input int s);
    return s == 2 ? 217 : 4;
  endfunction

  function automatic int sb_of(input int s);
    return s == 1 ? 2 : 1;
  endfunction

  task automatic cmp(input string n, input int a, input int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
  endtask

  // Model: q holds the line level for every remaining cycle of the frame in flight
  task automatic model_step();
    int c = cpb_of(sel);
    bit acc = valid && !m_full;
    logic [10:0] fr;
    if (rst) begin
      q.delete();
      m_full = 0;
      return;
    end
    if (q.size() > 0) void'(q.pop_front());
    if (m_full && q.size() == 0) begin
      fr = {2'b11, m_byte, 1'b0};
      for (int b = 0; b < 9 + sb_of(sel); b++)
        repeat (c) q.push_back(fr[b]);
      m_full = 0;
    end
    if (acc) begin
      m_full = 1;
      m_byte = data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp("line", ser[sel], q.size() > 0 ? int'(q[0]) : 1);
    cmp("active", act[sel], q.size() > 0);
    cmp("done", dn[sel], q.size() == 1);
    cmp("ready", rdy[sel], !m_full);
    lg.push_back(ser[sel]);
  endtask

  task automatic reset_to(input int s);
    rst = 1;
    valid = 0;
    sel = s;
    tick();
    cmp("reset_line", ser[s], 1);
    cmp("reset_ready", rdy[s], 1);
    cmp("reset_active", act[s], 0);
    cmp("reset_done", dn[s], 0);
    rst = 0;
    lg.delete();
  endtask

  // Independent receiver: find a falling edge, sample each bit mid-period
  task automatic decode(input int c);
    int i = 0;
    logic [7:0] b;
    rx_b.delete();
    rx_t.delete();
    while (i + 10 * c <= lg.size()) begin
      if (lg[i] == 0) begin
        for (int k = 0; k < 8; k++) b[k] = lg[i + c / 2 + (k + 1) * c];
        if (lg[i + c / 2 + 9 * c] == 1) begin
          rx_b.push_back(b);
          rx_t.push_back(i);
        end
        i = i + c / 2 + 9 * c + 1;
      end else i++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int c = cpb_of(v.sel);
    reset_to(v.sel);
    data = v.b;
    valid = 1;
    tick();
    valid = 0;
    cmp("vec_accept_ready", rdy[sel], 0);
    for (int i = 0; i < v.len; i++) begin
      tick();
      cmp("vec_line", ser[sel], v.pat[i / c]);
      cmp("vec_done", dn[sel], i == v.len - 1);
      cmp("vec_active", act[sel], 1);
      if (i == 0) cmp("vec_ready_back", rdy[sel], 1);
    end
    tick();
    cmp("vec_idle", act[sel], 0);
  endtask

  initial begin
    int n, gaps, lows;
    logic r;
    vecs = '{
      '{0, 8'h55, 40, {2'b11, 8'h55, 1'b0}},
      '{1, 8'h00, 44, {2'b11, 8'h00, 1'b0}},
      '{2, 8'h41, 2170, {2'b11, 8'h41, 1'b0}},
      '{0, 8'hA3, 40, {2'b11, 8'hA3, 1'b0}},
      '{0, 8'h0F, 40, {2'b11, 8'h0F, 1'b0}},
      '{1, 8'hFF, 44, {2'b11, 8'hFF, 1'b0}}
    };
    foreach (vecs[k]) run_vec(vecs[k]);

    reset_to(0);
    data = 8'hA3;
    valid = 1;
    tick();
    valid = 0;
    repeat (15) tick();
    data = 8'h0F;
    valid = 1;
    tick();
    valid = 0;
    cmp("b2b_held_ready", rdy[0], 0);
    gaps = 0;
    while (lg.size() < 90) begin
      tick();
      cmp("b2b_ready", rdy[0], lg.size() - 1 >= 41);
      if (lg.size() - 1 <= 80 && !act[0]) gaps++;
    end
    cmp("b2b_gaps", gaps, 0);
    cmp("b2b_no_idle", lg[41], 0);
    decode(4);
    cmp("b2b_frames", rx_b.size(), 2);
    if (rx_b.size() == 2) begin
      cmp("b2b_byte0", rx_b[0], 8'hA3);
      cmp("b2b_byte1", rx_b[1], 8'h0F);
      cmp("b2b_spacing", rx_t[1] - rx_t[0], 40);
    end

    reset_to(0);
    data = 8'hFF;
    valid = 1;
    tick();
    valid = 0;
    repeat (8) tick();
    data = 8'h81;
    valid = 1;
    tick();
    valid = 0;
    cmp("rst_held", rdy[0], 0);
    repeat (3) tick();
    rst = 1;
    valid = 1;
    tick();
    valid = 0;
    cmp("rst_line", ser[0], 1);
    cmp("rst_ready", rdy[0], 1);
    cmp("rst_active", act[0], 0);
    rst = 0;
    lg.delete();
    lows = 0;
    repeat (60) begin
      tick();
      if (!ser[0]) lows++;
    end
    cmp("rst_no_frame", lows, 0);
    cmp("rst_idle", act[0], 0);

    reset_to(0);
    data = 0;
    valid = 1;
    n = 0;
    for (int t = 0; t < 200; t++) begin
      r = rdy[0];
      tick();
      if (r && valid) begin
        n++;
        data = data + 8'd1;
        valid = n < 4;
      end
    end
    decode(4);
    cmp("stream_frames", rx_b.size(), 4);
    foreach (rx_b[k]) cmp("stream_byte", rx_b[k], k);
    for (int k = 1; k < rx_t.size(); k++) cmp("stream_spacing", rx_t[k] - rx_t[k-1], 40);

    for (int s = 0; s < 2; s++) begin
      reset_to(s);
      for (int t = 0; t < 3000; t++) begin
        valid = $urandom_range(0, 3) != 0;
        data = 8'($urandom);
        rst = $urandom_range(0, 399) == 0;
        tick();
      end
      rst = 0;
      valid = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
